// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher helpers: inverse S-box, GF(2^8) arithmetic and the
// 128-bit inverse round transforms. Byte 0 sits in bits 127:120, column-major.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } inv_phase_e;

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // First row of the InvMixColumns circulant; row r is this rotated right by r.
    localparam logic [0:3][7:0] IMC_COEF = {8'h0e, 8'h0b, 8'h0d, 8'h09};

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    function automatic logic [7:0] get_byte(input logic [127:0] s, input int r, input int c);
        return s[127 - 8*(4*c + r) -: 8];
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = get_byte(s, r, (c - r + 4) % 4);
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++)
            o[127 - 8*k -: 8] = inv_sbox(s[127 - 8*k -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   acc;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(IMC_COEF[(j - r + 4) % 4], get_byte(s, j, c));
                o[127 - 8*(4*c + r) -: 8] = acc;
            end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rk_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    logic [127:0] keyed;

    assign keyed   = inv_sub_bytes(inv_shift_rows(state_i)) ^ rk_i;
    assign state_o = last_i ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher, one round per clock, driven by a pre-expanded
// key schedule; plain_out exposes every intermediate round state.
//
//   state   | meaning
//   ST_IDLE | rnd=0, waiting for an enabled edge to load cipher_in ^ rk[NR]
//   ST_RUN  | rnd=1..NR, applying one inverse round per enabled edge
//   ST_DONE | plaintext held, done=1, until en drops
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [32*NK-1:0]      key_in,
    input  logic                  en,
    input  logic [127:0]          cipher_in,
    input  logic [(NR+1)*128-1:0] key_sched,
    output logic [127:0]          plain_out,
    output logic                  done
);

    localparam int RW = $clog2(NR + 1);

    inv_phase_e    phase_q, phase_d;
    logic [RW-1:0] rnd_q, rnd_d;
    logic [127:0]  state_q, state_d;
    logic [127:0]  rk_sel;
    logic [127:0]  round_out;
    logic          unused_key;

    // key_in only exists for interface compatibility with the encrypt side.
    assign unused_key = ^key_in;

    // Round key NR-rnd lives at bit offset rnd*128, so rnd=0 also picks rk[NR].
    always_comb begin
        rk_sel = '0;
        for (int i = 0; i <= NR; i++)
            if (rnd_q == RW'(i)) rk_sel = key_sched[i*128 +: 128];
    end

    aes_inv_round u_round (
        .state_i (state_q),
        .rk_i    (rk_sel),
        .last_i  (rnd_q == RW'(NR)),
        .state_o (round_out)
    );

    always_comb begin
        phase_d = phase_q;
        rnd_d   = rnd_q;
        state_d = state_q;
        if (!en) begin
            phase_d = ST_IDLE;
            rnd_d   = '0;
        end else begin
            case (phase_q)
                ST_IDLE: begin
                    state_d = cipher_in ^ rk_sel;
                    rnd_d   = RW'(1);
                    phase_d = ST_RUN;
                end
                ST_RUN: begin
                    state_d = round_out;
                    if (rnd_q == RW'(NR)) phase_d = ST_DONE;
                    else                  rnd_d   = rnd_q + 1'b1;
                end
                ST_DONE: ;
                default: begin
                    phase_d = ST_IDLE;
                    rnd_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= ST_IDLE;
            rnd_q   <= '0;
            state_q <= '0;
        end else begin
            phase_q <= phase_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
        end
    end

    assign plain_out = state_q;
    assign done      = (phase_q == ST_DONE);

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: AES-128/192/256 instances checked edge by edge
// against a byte-array model of FIPS-197 InvCipher built from first principles.
module tb_aes_inv_cipher_iter;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en   [3];
    logic [127:0]  cin  [3];
    logic [127:0]  pout [3];
    logic          dn   [3];
    logic [127:0]  key0;
    logic [191:0]  key1;
    logic [255:0]  key2;
    logic [1407:0] ks0;
    logic [1663:0] ks1;
    logic [1919:0] ks2;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0]    sbox [256];
    logic [7:0]    isb  [256];
    logic [7:0]    imix [4][4];
    logic [127:0]  exp_tr [15];
    logic [255:0]  kat_key [3];
    logic [127:0]  kat_ct  [3];
    logic [1919:0] kat_ks  [3];

    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

    always #5 clk = ~clk;

    aes_inv_cipher_iter #(.NK(4), .NR(10)) dut128 (
        .clk(clk), .rst_n(rst_n), .key_in(key0), .en(en[0]), .cipher_in(cin[0]),
        .key_sched(ks0), .plain_out(pout[0]), .done(dn[0]));
    aes_inv_cipher_iter #(.NK(6), .NR(12)) dut192 (
        .clk(clk), .rst_n(rst_n), .key_in(key1), .en(en[1]), .cipher_in(cin[1]),
        .key_sched(ks1), .plain_out(pout[1]), .done(dn[1]));
    aes_inv_cipher_iter #(.NK(8), .NR(14)) dut256 (
        .clk(clk), .rst_n(rst_n), .key_in(key2), .en(en[2]), .cipher_in(cin[2]),
        .key_sched(ks2), .plain_out(pout[2]), .done(dn[2]));

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x};
        return d[15-n -: 8];
    endfunction

    // S-box from the multiplicative inverse plus the affine map; the inverse table is its inversion.
    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[x] = s;
            isb[s]  = 8'(x);
        end
        imix[0][0] = 8'h0e; imix[0][1] = 8'h0b; imix[0][2] = 8'h0d; imix[0][3] = 8'h09;
        imix[1][0] = 8'h09; imix[1][1] = 8'h0e; imix[1][2] = 8'h0b; imix[1][3] = 8'h0d;
        imix[2][0] = 8'h0d; imix[2][1] = 8'h09; imix[2][2] = 8'h0e; imix[2][3] = 8'h0b;
        imix[3][0] = 8'h0b; imix[3][1] = 8'h0d; imix[3][2] = 8'h09; imix[3][3] = 8'h0e;
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [1919:0] key_expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1919:0] ks;
        rcon = 8'h01;
        ks   = '0;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gf_mul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i <= nr; i++)
            ks[(nr+1-i)*128-1 -: 128] = {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
        return ks;
    endfunction

    function automatic logic [127:0] m_round(input logic [127:0] s, input logic [127:0] rk, input bit last);
        logic [7:0]   st [4][4];
        logic [7:0]   t  [4][4];
        logic [7:0]   u;
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) st[r][c] = s[127 - 8*(4*c + r) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r][(c + r) % 4] = isb[st[r][c]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r][c] = t[r][c] ^ rk[127 - 8*(4*c + r) -: 8];
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                if (last) u = t[r][c];
                else begin
                    u = 8'h00;
                    for (int j = 0; j < 4; j++) u = u ^ gf_mul(imix[r][j], t[j][c]);
                end
                o[127 - 8*(4*c + r) -: 8] = u;
            end
        return o;
    endfunction

    // exp_tr[k] is the state expected on plain_out after enabled edge k+1.
    task automatic model_trace(input int nr, input logic [127:0] c, input logic [1919:0] ks);
        exp_tr[0] = c ^ ks[127:0];
        for (int k = 1; k <= nr; k++)
            exp_tr[k] = m_round(exp_tr[k-1], ks[(k+1)*128-1 -: 128], k == nr);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int v, input logic [255:0] key, input logic [1919:0] ks);
        case (v)
            0: begin key0 = key[255:128]; ks0 = ks[1407:0]; end
            1: begin key1 = key[255:64];  ks1 = ks[1663:0]; end
            default: begin key2 = key; ks2 = ks; end
        endcase
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        for (int v = 0; v < 3; v++) begin
            vec_cnt++;
            if (pout[v] !== 128'h0 || dn[v] !== 1'b0) begin
                err_cnt++;
                $display("FAIL reset v%0d: plain_out=%h done=%b, want 0/0", v, pout[v], dn[v]);
            end
        end
    endtask

    task automatic test_kat();
        int nr;
        kat_key[0] = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        kat_key[1] = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
        kat_key[2] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        kat_ct[0]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        kat_ct[1]  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        kat_ct[2]  = 128'h8ea2b7ca516745bfeafc49904b496089;
        for (int v = 0; v < 3; v++) begin
            nr = 10 + 2*v;
            kat_ks[v] = key_expand(kat_key[v], 4 + 2*v, nr);
            load(v, kat_key[v], kat_ks[v]);
            model_trace(nr, kat_ct[v], kat_ks[v]);
            cin[v] = kat_ct[v];
            en[v]  = 1'b1;
            for (int e = 1; e <= nr + 1; e++) begin
                tick();
                vec_cnt++;
                if (pout[v] !== exp_tr[e-1] || dn[v] !== (e == nr + 1)) begin
                    err_cnt++;
                    $display("FAIL kat v%0d edge %0d: plain_out=%h done=%b, want %h/%b",
                             v, e, pout[v], dn[v], exp_tr[e-1], e == nr + 1);
                end
                if (v == 0 && e == 1) begin
                    vec_cnt++;
                    if (pout[0] !== 128'h7ad5fda789ef4e272bca100b3d9ff59f) begin
                        err_cnt++;
                        $display("FAIL kat128 first edge: plain_out=%h, want 7ad5fda789ef4e272bca100b3d9ff59f", pout[0]);
                    end
                end
            end
            vec_cnt++;
            if (pout[v] !== PT) begin
                err_cnt++;
                $display("FAIL kat v%0d plaintext: plain_out=%h, want %h", v, pout[v], PT);
            end
            en[v] = 1'b0;
            tick();
        end
    endtask

    task automatic test_hold_abort();
        logic [127:0] c2;
        model_trace(10, kat_ct[0], kat_ks[0]);
        cin[0] = kat_ct[0];
        en[0]  = 1'b1;
        repeat (11) tick();
        for (int e = 0; e < 5; e++) begin
            cin[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
            vec_cnt++;
            if (pout[0] !== PT || dn[0] !== 1'b1) begin
                err_cnt++;
                $display("FAIL hold extra edge %0d: plain_out=%h done=%b, want %h/1", e, pout[0], dn[0], PT);
            end
        end
        en[0] = 1'b0;
        tick();
        cin[0] = kat_ct[0];
        en[0]  = 1'b1;
        repeat (4) tick();
        en[0] = 1'b0;
        for (int e = 0; e < 2; e++) begin
            tick();
            vec_cnt++;
            if (pout[0] !== exp_tr[3] || dn[0] !== 1'b0) begin
                err_cnt++;
                $display("FAIL abort frozen %0d: plain_out=%h done=%b, want %h/0", e, pout[0], dn[0], exp_tr[3]);
            end
        end
        c2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        model_trace(10, c2, kat_ks[0]);
        cin[0] = c2;
        en[0]  = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            tick();
            vec_cnt++;
            if (pout[0] !== exp_tr[e-1] || dn[0] !== (e == 11)) begin
                err_cnt++;
                $display("FAIL restart edge %0d: plain_out=%h done=%b, want %h/%b",
                         e, pout[0], dn[0], exp_tr[e-1], e == 11);
            end
        end
        en[0] = 1'b0;
        tick();
    endtask

    task automatic test_cin_change();
        cin[2] = kat_ct[2];
        en[2]  = 1'b1;
        tick();
        cin[2] = 128'h0;
        repeat (14) tick();
        vec_cnt++;
        if (pout[2] !== PT || dn[2] !== 1'b1) begin
            err_cnt++;
            $display("FAIL cin_change: plain_out=%h done=%b, want %h/1", pout[2], dn[2], PT);
        end
        en[2] = 1'b0;
        tick();
    endtask

    task automatic test_async_mid_run();
        model_trace(12, kat_ct[1], kat_ks[1]);
        cin[1] = kat_ct[1];
        en[1]  = 1'b1;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (pout[1] !== 128'h0 || dn[1] !== 1'b0) begin
            err_cnt++;
            $display("FAIL async reset mid-run: plain_out=%h done=%b, want 0/0", pout[1], dn[1]);
        end
        tick();
        vec_cnt++;
        if (pout[1] !== 128'h0) begin
            err_cnt++;
            $display("FAIL reset held with en: plain_out=%h, want 0", pout[1]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vec_cnt++;
        if (pout[1] !== exp_tr[0] || dn[1] !== 1'b0) begin
            err_cnt++;
            $display("FAIL start after reset: plain_out=%h done=%b, want %h/0", pout[1], dn[1], exp_tr[0]);
        end
        en[1] = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [255:0]  key;
        logic [127:0]  c;
        logic [1919:0] ks;
        int nr;
        for (int it = 0; it < 4; it++)
            for (int v = 0; v < 3; v++) begin
                nr  = 10 + 2*v;
                key = {$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom(), $urandom()};
                c   = {$urandom(), $urandom(), $urandom(), $urandom()};
                ks  = key_expand(key, 4 + 2*v, nr);
                load(v, key, ks);
                model_trace(nr, c, ks);
                cin[v] = c;
                en[v]  = 1'b1;
                for (int e = 1; e <= nr + 1; e++) begin
                    tick();
                    vec_cnt++;
                    if (pout[v] !== exp_tr[e-1] || dn[v] !== (e == nr + 1)) begin
                        err_cnt++;
                        $display("FAIL random it%0d v%0d edge %0d: plain_out=%h done=%b, want %h/%b",
                                 it, v, e, pout[v], dn[v], exp_tr[e-1], e == nr + 1);
                    end
                end
                en[v] = 1'b0;
                tick();
                vec_cnt++;
                if (pout[v] !== exp_tr[nr] || dn[v] !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL random rearm it%0d v%0d: plain_out=%h done=%b, want %h/0",
                             it, v, pout[v], dn[v], exp_tr[nr]);
                end
            end
    endtask

    initial begin
        rst_n = 1'b1;
        for (int v = 0; v < 3; v++) begin
            en[v]  = 1'b0;
            cin[v] = 128'h0;
        end
        key0 = '0; key1 = '0; key2 = '0;
        ks0  = '0; ks1  = '0; ks2  = '0;
        build_tables();
        #2;
        test_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_kat();
        test_hold_abort();
        test_cin_change();
        test_async_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
